// File: rtl/sdram_init_monitor_if.sv
// SDRAM command-bus tap and init-monitor status bundle.
// The master drives the command pins; the slave is the monitor that reports status.
interface sdram_init_monitor_if;
  logic [3:0]  cmd_reg;
  logic [11:0] sdram_addr;
  logic        init_done;
  logic        err;
  logic [2:0]  err_code;
  logic [11:0] mode_reg;
  logic [7:0]  refresh_cnt;
  logic [2:0]  state;

  modport master (
    output cmd_reg, sdram_addr,
    input  init_done, err, err_code, mode_reg, refresh_cnt, state
  );

  modport slave (
    input  cmd_reg, sdram_addr,
    output init_done, err, err_code, mode_reg, refresh_cnt, state
  );
endinterface

// File: rtl/sdram_init_monitor.sv
// Samples the SDRAM command bus like the device does and checks the power-up
// sequence PRE-all -> 2x AUTO_REFRESH -> MODE_SET, its command gaps and mode value.
module sdram_init_monitor #(
  parameter int unsigned T_POWERUP = 10001,
  parameter int unsigned T_RP      = 1,
  parameter int unsigned T_RFC     = 4,
  parameter int unsigned T_MRD     = 2
) (
  input logic                 sclk,
  input logic                 reset,
  sdram_init_monitor_if.slave bus
);
  localparam logic [2:0] S_PWR      = 3'd0;
  localparam logic [2:0] S_WAIT_PRE = 3'd1;
  localparam logic [2:0] S_WAIT_AR1 = 3'd2;
  localparam logic [2:0] S_WAIT_AR2 = 3'd3;
  localparam logic [2:0] S_WAIT_MRS = 3'd4;
  localparam logic [2:0] S_WAIT_MRD = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;
  localparam logic [2:0] S_ERR      = 3'd7;

  localparam logic [2:0] C_NOP = 3'd0;
  localparam logic [2:0] C_PRE = 3'd1;
  localparam logic [2:0] C_AR  = 3'd2;
  localparam logic [2:0] C_MRS = 3'd3;
  localparam logic [2:0] C_OTH = 3'd4;

  localparam logic [2:0] E_NONE  = 3'd0;
  localparam logic [2:0] E_ORDER = 3'd1;
  localparam logic [2:0] E_GAP   = 3'd2;
  localparam logic [2:0] E_A10   = 3'd3;
  localparam logic [2:0] E_MODE  = 3'd4;

  localparam int unsigned      PWR_W    = (T_POWERUP < 2) ? 1 : $clog2(T_POWERUP + 1);
  localparam logic [PWR_W-1:0] PWR_LAST = PWR_W'(T_POWERUP);
  localparam logic [PWR_W-1:0] PWR_ONE  = PWR_W'(1);
  localparam logic [3:0]       RP_MIN   = 4'(T_RP);
  localparam logic [3:0]       RFC_MIN  = 4'(T_RFC);
  localparam logic [3:0]       MRD_MIN  = 4'(T_MRD);

  function automatic logic [2:0] decode_cmd(input logic [3:0] c);
    logic [2:0] k;
    if (c[3] || c == 4'b0111) k = C_NOP;
    else begin
      case (c)
        4'b0010: k = C_PRE;
        4'b0001: k = C_AR;
        4'b0000: k = C_MRS;
        default: k = C_OTH;
      endcase
    end
    return k;
  endfunction

  // CAS latency 2/3 only; burst length 1/2/4/8 or full page; A3 (burst type) is free.
  function automatic logic mode_legal(input logic [11:0] a);
    logic cl_ok;
    logic bl_ok;
    cl_ok = (a[6:4] == 3'b010) || (a[6:4] == 3'b011);
    bl_ok = (a[2] == 1'b0) || (a[2:0] == 3'b111);
    return (a[11:7] == 5'd0) && cl_ok && bl_ok;
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [2:0]       state_q, state_d;
  logic [PWR_W-1:0] pwr_cnt_q, pwr_cnt_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic [2:0]       prev_kind_q, prev_kind_d;
  logic             init_done_q, init_done_d;
  logic             err_q, err_d;
  logic [2:0]       err_code_q, err_code_d;
  logic [11:0]      mode_reg_q, mode_reg_d;
  logic [7:0]       refresh_cnt_q, refresh_cnt_d;

  logic [2:0] cmd_kind;
  logic       is_nop;
  logic [2:0] eff_state;
  logic [3:0] gap_eff;
  logic       checking;
  logic [2:0] exp_kind;
  logic [3:0] gap_min;
  logic [2:0] err_cause;

  always_comb begin
    cmd_kind  = decode_cmd(bus.cmd_reg);
    is_nop    = (cmd_kind == C_NOP);
    eff_state = state_q;
    gap_eff   = gap_cnt_q;
    // The edge that closes the power-up window (or the MRD wait) already judges
    // its own sample under the following state.
    if (state_q == S_PWR && pwr_cnt_q == PWR_LAST) begin
      eff_state = S_WAIT_PRE;
      gap_eff   = 4'hF;
    end else if (state_q == S_WAIT_MRD && gap_cnt_q >= MRD_MIN) begin
      eff_state = S_DONE;
    end
    checking = (eff_state != S_PWR) && (eff_state != S_ERR);

    case (eff_state)
      S_WAIT_PRE:             exp_kind = C_PRE;
      S_WAIT_AR1, S_WAIT_AR2: exp_kind = C_AR;
      S_WAIT_MRS:             exp_kind = C_MRS;
      default:                exp_kind = C_NOP;
    endcase

    case (prev_kind_q)
      C_PRE:   gap_min = RP_MIN;
      C_AR:    gap_min = RFC_MIN;
      C_MRS:   gap_min = MRD_MIN;
      default: gap_min = 4'd0;
    endcase

    err_cause = E_NONE;
    if (checking && !is_nop) begin
      if (eff_state != S_DONE && cmd_kind != exp_kind)
        err_cause = E_ORDER;
      else if (gap_eff < gap_min)
        err_cause = E_GAP;
      else if (cmd_kind == C_PRE && eff_state == S_WAIT_PRE && !bus.sdram_addr[10])
        err_cause = E_A10;
      else if (cmd_kind == C_MRS && !mode_legal(bus.sdram_addr))
        err_cause = E_MODE;
    end

    state_d       = state_q;
    pwr_cnt_d     = pwr_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    prev_kind_d   = prev_kind_q;
    init_done_d   = init_done_q;
    err_d         = err_q;
    err_code_d    = err_code_q;
    mode_reg_d    = mode_reg_q;
    refresh_cnt_d = refresh_cnt_q;

    if (eff_state == S_PWR) pwr_cnt_d = pwr_cnt_q + PWR_ONE;

    if (checking) begin
      gap_cnt_d = is_nop ? sat_inc4(gap_eff) : 4'd1;
      state_d   = eff_state;
      if (err_cause != E_NONE) begin
        state_d     = S_ERR;
        err_d       = 1'b1;
        err_code_d  = err_cause;
        init_done_d = 1'b0;
      end else begin
        if (!is_nop) prev_kind_d = cmd_kind;
        if (eff_state == S_DONE) init_done_d = 1'b1;
        if (cmd_kind == C_MRS) mode_reg_d = bus.sdram_addr;
        if (cmd_kind == C_AR && eff_state == S_DONE) refresh_cnt_d = sat_inc8(refresh_cnt_q);
        if (!is_nop && eff_state != S_DONE) state_d = eff_state + 3'd1;
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (!reset) begin
      state_q       <= S_PWR;
      pwr_cnt_q     <= '0;
      gap_cnt_q     <= 4'd0;
      prev_kind_q   <= C_NOP;
      init_done_q   <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= E_NONE;
      mode_reg_q    <= 12'd0;
      refresh_cnt_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      pwr_cnt_q     <= pwr_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      prev_kind_q   <= prev_kind_d;
      init_done_q   <= init_done_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      mode_reg_q    <= mode_reg_d;
      refresh_cnt_q <= refresh_cnt_d;
    end
  end

  assign bus.init_done   = init_done_q;
  assign bus.err         = err_q;
  assign bus.err_code    = err_code_q;
  assign bus.mode_reg    = mode_reg_q;
  assign bus.refresh_cnt = refresh_cnt_q;
  assign bus.state       = state_q;
endmodule

// File: tb/tb_sdram_init_monitor.sv
// Bench for sdram_init_monitor: directed power-up scenarios plus randomized
// command streams checked against a timestamp-based model of the sequence rules.
module tb_sdram_init_monitor;
  localparam int P     = 64;
  localparam int T_RP  = 1;
  localparam int T_RFC = 4;
  localparam int T_MRD = 2;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] AR  = 4'b0001;
  localparam logic [3:0] MRS = 4'b0000;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] ACT = 4'b0011;

  logic sclk  = 1'b0;
  logic reset = 1'b0;
  always #5 sclk = ~sclk;

  sdram_init_monitor_if bus();

  sdram_init_monitor #(
    .T_POWERUP(P), .T_RP(T_RP), .T_RFC(T_RFC), .T_MRD(T_MRD)
  ) dut (
    .sclk (sclk),
    .reset(reset),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: sample index since reset release, init progress and command timestamps.
  int          m_n, m_phase, m_last_t, m_last_kind, m_code, m_ref;
  bit          m_err, m_done;
  logic [11:0] m_mode;

  function automatic int kind_of(input logic [3:0] c);
    if (c[3] || c == 4'b0111) return 0;
    case (c)
      4'b0010: return 1;
      4'b0001: return 2;
      4'b0000: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int expect_kind(input int phase);
    case (phase)
      0:       return 1;
      1, 2:    return 2;
      3:       return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int min_gap(input int k);
    case (k)
      1:       return T_RP;
      2:       return T_RFC;
      3:       return T_MRD;
      default: return 0;
    endcase
  endfunction

  function automatic bit mode_legal(input logic [11:0] a);
    int cl, bl;
    cl = int'(a[6:4]);
    bl = int'(a[2:0]);
    return (a[11:7] == 5'd0) && (cl == 2 || cl == 3) && (bl <= 3 || bl == 7);
  endfunction

  function automatic logic [2:0] exp_state();
    if (m_err) return 3'd7;
    if (m_n <= P) return 3'd0;
    if (m_phase == 5) return 3'd6;
    return 3'(m_phase + 1);
  endfunction

  task automatic model_reset();
    m_n = 0; m_phase = 0; m_last_t = -100; m_last_kind = 0;
    m_code = 0; m_ref = 0; m_err = 0; m_done = 0; m_mode = 12'd0;
  endtask

  task automatic model_step(input logic [3:0] c, input logic [11:0] a);
    int k, gap, code;
    k = kind_of(c);
    if (!m_err && m_n >= P) begin
      gap = m_n - m_last_t;
      if (gap > 15) gap = 15;
      if (m_phase == 4 && gap == T_MRD) begin
        m_phase = 5;
        m_done  = 1;
      end
      if (k != 0) begin
        code = 0;
        if (m_phase < 5 && k != expect_kind(m_phase)) code = 1;
        else if (gap < min_gap(m_last_kind))          code = 2;
        else if (k == 1 && m_phase == 0 && !a[10])    code = 3;
        else if (k == 3 && !mode_legal(a))            code = 4;
        if (code != 0) begin
          m_err = 1; m_code = code; m_done = 0;
        end else begin
          if (k == 2 && m_phase == 5 && m_ref < 255) m_ref++;
          if (k == 3) m_mode = a;
          if (m_phase < 5) m_phase++;
          m_last_t    = m_n;
          m_last_kind = k;
        end
      end
    end
    m_n++;
  endtask

  task automatic cycle(input logic [3:0] c, input logic [11:0] a);
    bus.cmd_reg    = c;
    bus.sdram_addr = a;
    @(posedge sclk);
    model_step(c, a);
    @(negedge sclk);
  endtask

  task automatic do_reset(input int edges);
    reset          = 1'b0;
    bus.cmd_reg    = NOP;
    bus.sdram_addr = 12'd0;
    repeat (edges) @(posedge sclk);
    model_reset();
    @(negedge sclk);
    reset = 1'b1;
  endtask

  task automatic powerup();
    do_reset(1);
    repeat (P) cycle(MRS, 12'h000);
  endtask

  task automatic drive_init();
    cycle(PRE, 12'h400);
    cycle(AR, 12'h000);
    repeat (3) cycle(NOP, 12'h000);
    cycle(AR, 12'h000);
    repeat (3) cycle(NOP, 12'h000);
    cycle(MRS, 12'h032);
    repeat (2) cycle(NOP, 12'h000);
  endtask

  task automatic test_reset();
    do_reset(3);
    n_tests++;
    if ({bus.init_done, bus.err, bus.err_code, bus.mode_reg, bus.refresh_cnt} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got done=%b err=%b code=%0d mode=%h ref=%0d, want all 0",
               bus.init_done, bus.err, bus.err_code, bus.mode_reg, bus.refresh_cnt);
    end
    n_tests++;
    if (bus.state !== 3'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d want 0", bus.state);
    end
  endtask

  task automatic test_nominal();
    powerup();
    n_tests++;
    if (bus.state !== 3'd0) begin
      n_fail++; $display("FAIL nominal_window: state %0d want 0", bus.state);
    end
    cycle(PRE, 12'h400);
    n_tests++;
    if (bus.state !== 3'd2) begin
      n_fail++; $display("FAIL nominal_pre: state %0d want 2", bus.state);
    end
    cycle(AR, 12'h000);
    repeat (3) cycle(NOP, 12'h000);
    cycle(AR, 12'h000);
    n_tests++;
    if (bus.state !== 3'd4) begin
      n_fail++; $display("FAIL nominal_ar2: state %0d want 4", bus.state);
    end
    repeat (3) cycle(NOP, 12'h000);
    cycle(MRS, 12'h032);
    cycle(NOP, 12'h000);
    n_tests++;
    if (bus.init_done !== 1'b0 || bus.state !== 3'd5) begin
      n_fail++; $display("FAIL nominal_mrd: done=%b state=%0d want done=0 state=5", bus.init_done, bus.state);
    end
    cycle(NOP, 12'h000);
    n_tests++;
    if ({bus.init_done, bus.err, bus.mode_reg, bus.state} !== {1'b1, 1'b0, 12'h032, 3'd6}) begin
      n_fail++;
      $display("FAIL nominal_done: done=%b err=%b mode=%h state=%0d want 1 0 032 6",
               bus.init_done, bus.err, bus.mode_reg, bus.state);
    end
  endtask

  task automatic test_gap_err();
    powerup();
    cycle(PRE, 12'h400);
    cycle(AR, 12'h000);
    repeat (2) cycle(NOP, 12'h000);
    cycle(AR, 12'h000);
    n_tests++;
    if ({bus.init_done, bus.err, bus.err_code, bus.state} !== {1'b0, 1'b1, 3'd2, 3'd7}) begin
      n_fail++;
      $display("FAIL gap_err: done=%b err=%b code=%0d state=%0d want 0 1 2 7",
               bus.init_done, bus.err, bus.err_code, bus.state);
    end
  endtask

  task automatic test_pre_a10();
    powerup();
    cycle(PRE, 12'h000);
    n_tests++;
    if ({bus.err, bus.err_code, bus.state} !== {1'b1, 3'd3, 3'd7}) begin
      n_fail++; $display("FAIL pre_a10: err=%b code=%0d state=%0d want 1 3 7", bus.err, bus.err_code, bus.state);
    end
  endtask

  task automatic test_ar_first();
    powerup();
    cycle(AR, 12'h400);
    n_tests++;
    if ({bus.err, bus.err_code, bus.state} !== {1'b1, 3'd1, 3'd7}) begin
      n_fail++; $display("FAIL ar_first: err=%b code=%0d state=%0d want 1 1 7", bus.err, bus.err_code, bus.state);
    end
  endtask

  task automatic test_mode_illegal();
    powerup();
    cycle(PRE, 12'h400);
    cycle(AR, 12'h000);
    repeat (3) cycle(NOP, 12'h000);
    cycle(AR, 12'h000);
    repeat (3) cycle(NOP, 12'h000);
    cycle(MRS, 12'h052);
    n_tests++;
    if ({bus.err, bus.err_code, bus.mode_reg, bus.init_done} !== {1'b1, 3'd4, 12'h000, 1'b0}) begin
      n_fail++;
      $display("FAIL mode_illegal: err=%b code=%0d mode=%h done=%b want 1 4 000 0",
               bus.err, bus.err_code, bus.mode_reg, bus.init_done);
    end
  endtask

  task automatic test_done_cmds();
    powerup();
    drive_init();
    cycle(PRE, 12'h000);
    cycle(ACT, 12'h123);
    repeat (4) cycle(NOP, 12'h000);
    cycle(MRS, 12'h023);
    n_tests++;
    if ({bus.init_done, bus.err, bus.mode_reg, bus.state} !== {1'b1, 1'b0, 12'h023, 3'd6}) begin
      n_fail++;
      $display("FAIL done_reload: done=%b err=%b mode=%h state=%0d want 1 0 023 6",
               bus.init_done, bus.err, bus.mode_reg, bus.state);
    end
    cycle(MRS, 12'h032);
    n_tests++;
    if ({bus.err, bus.err_code, bus.mode_reg, bus.init_done} !== {1'b1, 3'd2, 12'h023, 1'b0}) begin
      n_fail++;
      $display("FAIL done_mrd_gap: err=%b code=%0d mode=%h done=%b want 1 2 023 0",
               bus.err, bus.err_code, bus.mode_reg, bus.init_done);
    end
  endtask

  task automatic test_refresh_sat();
    powerup();
    drive_init();
    for (int i = 1; i <= 300; i++) begin
      cycle(AR, 12'h000);
      repeat (3) cycle(NOP, 12'h000);
      if (i == 200 || i == 300) begin
        n_tests++;
        if (bus.refresh_cnt !== 8'((i > 255) ? 255 : i) || bus.err !== 1'b0) begin
          n_fail++;
          $display("FAIL refresh_cnt@%0d: got %0d err=%b want %0d err=0",
                   i, bus.refresh_cnt, bus.err, (i > 255) ? 255 : i);
        end
      end
    end
    do_reset(1);
    n_tests++;
    if ({bus.init_done, bus.err, bus.err_code, bus.mode_reg, bus.refresh_cnt, bus.state} !== 28'd0) begin
      n_fail++;
      $display("FAIL mid_reset: done=%b err=%b code=%0d mode=%h ref=%0d state=%0d want all 0",
               bus.init_done, bus.err, bus.err_code, bus.mode_reg, bus.refresh_cnt, bus.state);
    end
  endtask

  // Runs straight after the mid-stream reset: the window must restart from zero.
  task automatic test_read_in_ar2();
    for (int i = 0; i < P; i++) cycle((i == 5) ? PRE : MRS, 12'h000);
    n_tests++;
    if (bus.state !== 3'd0 || bus.err !== 1'b0) begin
      n_fail++; $display("FAIL rewindow: state=%0d err=%b want 0 0", bus.state, bus.err);
    end
    cycle(PRE, 12'h400);
    cycle(AR, 12'h000);
    repeat (3) cycle(NOP, 12'h000);
    cycle(RD, 12'h000);
    n_tests++;
    if ({bus.err, bus.err_code, bus.state} !== {1'b1, 3'd1, 3'd7}) begin
      n_fail++; $display("FAIL read_ar2: err=%b code=%0d state=%0d want 1 1 7", bus.err, bus.err_code, bus.state);
    end
    cycle(AR, 12'h000);
    repeat (3) cycle(NOP, 12'h000);
    cycle(MRS, 12'h032);
    repeat (3) cycle(NOP, 12'h000);
    n_tests++;
    if ({bus.err_code, bus.mode_reg, bus.init_done, bus.state} !== {3'd1, 12'h000, 1'b0, 3'd7}) begin
      n_fail++;
      $display("FAIL err_sticky: code=%0d mode=%h done=%b state=%0d want 1 000 0 7",
               bus.err_code, bus.mode_reg, bus.init_done, bus.state);
    end
  endtask

  task automatic test_random();
    logic [3:0]  c;
    logic [11:0] a;
    logic [2:0]  bl_tab [5];
    int          r, gap;
    logic [27:0] got, want;
    bl_tab = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd7};
    for (int it = 0; it < 25; it++) begin
      do_reset(1);
      for (int i = 0; i < P + 160; i++) begin
        r   = $urandom_range(0, 99);
        gap = m_n - m_last_t;
        if (r < 40) begin
          c = (r < 20) ? NOP : {1'b1, 3'($urandom_range(0, 7))};
        end else if (r < 90) begin
          case (m_phase)
            0:       c = PRE;
            1, 2:    c = AR;
            3:       c = MRS;
            4:       c = NOP;
            default: c = (r < 75) ? AR : ((r < 82) ? MRS : RD);
          endcase
          if (gap < min_gap(m_last_kind) && $urandom_range(0, 9) < 9) c = NOP;
        end else begin
          c = 4'($urandom_range(0, 15));
        end
        a = 12'($urandom_range(0, 4095));
        if (c == PRE && $urandom_range(0, 9) < 8) a[10] = 1'b1;
        if (c == MRS && $urandom_range(0, 9) < 8)
          a = {5'd0, ($urandom_range(0, 1) != 0) ? 3'b011 : 3'b010, a[3], bl_tab[$urandom_range(0, 4)]};
        cycle(c, a);
        got  = {bus.init_done, bus.err, bus.err_code, bus.mode_reg, bus.refresh_cnt, bus.state};
        want = {m_done, m_err, 3'(m_code), m_mode, 8'(m_ref), exp_state()};
        n_tests++;
        if (got !== want) begin
          n_fail++;
          $display("FAIL random it=%0d cyc=%0d cmd=%b addr=%h: got %h want %h", it, i, c, a, got, want);
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_reg    = NOP;
    bus.sdram_addr = 12'd0;
    model_reset();
    test_reset();
    test_nominal();
    test_gap_err();
    test_pre_a10();
    test_ar_first();
    test_mode_illegal();
    test_done_cmds();
    test_refresh_sat();
    test_read_in_ar2();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
